// File: rtl/decode_byte_aligner_pkg.sv
// decode_byte_aligner_pkg: shared sizes and byte-lane helpers for the decode byte queue
// Contents: queue geometry (LINE_BYTES, BUF_BYTES, CNT_W), the longest legal
// instruction length, and helpers to read or write one byte lane of the buffer.
package decode_byte_aligner_pkg;
  localparam int LINE_BYTES = 16;
  localparam int BUF_BYTES = 32;
  localparam int CNT_W = 6;
  localparam int MAX_INSN_BYTES = 15;
  localparam int BUF_W = BUF_BYTES * 8;

  function automatic logic [7:0] get_lane(input logic [BUF_W-1:0] d, input int i);
    return d[i*8 +: 8];
  endfunction

  function automatic logic [BUF_W-1:0] set_lane(input logic [BUF_W-1:0] d, input int i, input logic [7:0] b);
    logic [BUF_W-1:0] r;
    r = d;
    r[i*8 +: 8] = b;
    return r;
  endfunction
endpackage

// File: rtl/decode_byte_aligner_byte_shift.sv
// byte_shift_right: byte-granular barrel shifter with zero fill
// Ports: data_i  word to shift
//        amt_i   shift amount in bytes (0..31)
//        data_o  shifted word (toward byte 0, or away from it when LEFT=1)
module byte_shift_right #(
  parameter int W = 256,
  parameter bit LEFT = 1'b0
) (
  input  logic [W-1:0] data_i,
  input  logic [4:0]   amt_i,
  output logic [W-1:0] data_o
);
  logic [7:0] bits;
  assign bits = {amt_i, 3'b000};
  assign data_o = LEFT ? data_i << bits : data_i >> bits;
endmodule

// File: rtl/decode_byte_aligner.sv
// decode_byte_aligner: 32-byte queue aligning fetched bytes into a 16-byte decode window
// Ports: clk, reset (async, active-high)
//        flush                              discard all buffered bytes
//        fetch_data/fetch_valid/fetch_ready 16-byte fetch line in
//        window/window_bytes                byte-0-aligned view of the queue head
//        consume_valid/consume_bytes        bytes retired by decode
//        overrun                            sticky: decode retired more than was valid
module decode_byte_aligner
  import decode_byte_aligner_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic [127:0] fetch_data,
  input  logic         fetch_valid,
  output logic         fetch_ready,
  output logic [127:0] window,
  output logic [4:0]   window_bytes,
  input  logic         consume_valid,
  input  logic [4:0]   consume_bytes,
  output logic         overrun
);
  logic [CNT_W-1:0] count_q, count_d, rem;
  logic [BUF_W-1:0] buf_q, buf_d, shifted, placed;
  logic overrun_q, overrun_d;
  logic accept, over;
  logic [4:0] req, c;

  assign fetch_ready = count_q <= CNT_W'(BUF_BYTES - LINE_BYTES);
  assign accept = fetch_valid & fetch_ready;
  assign req = consume_valid ? consume_bytes : 5'd0;
  assign over = req > 5'd16 || {1'b0, req} > count_q;
  // An illegal or excessive consume retires everything visible, i.e. min(count,16).
  assign c = over ? window_bytes : req;
  assign rem = count_q - {1'b0, c};

  byte_shift_right #(.W(BUF_W), .LEFT(1'b0)) u_consume (
    .data_i(buf_q),
    .amt_i (c),
    .data_o(shifted)
  );

  // rem is at most 16 whenever a line is accepted, so its low 5 bits are the full offset.
  byte_shift_right #(.W(BUF_W), .LEFT(1'b1)) u_place (
    .data_i({{(BUF_W-128){1'b0}}, fetch_data}),
    .amt_i (rem[4:0]),
    .data_o(placed)
  );

  // Bytes beyond count stay zero: the consume shift zero-fills and the line lands exactly at rem.
  assign buf_d = flush ? '0 : shifted | (accept ? placed : '0);
  assign count_d = flush ? '0 : rem + (accept ? CNT_W'(LINE_BYTES) : CNT_W'(0));
  assign overrun_d = overrun_q | (~flush & over);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      buf_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      count_q <= count_d;
      buf_q <= buf_d;
      overrun_q <= overrun_d;
    end
  end

  for (genvar k = 0; k < LINE_BYTES; k++) begin : g_win
    assign window[k*8 +: 8] = CNT_W'(k) < count_q ? get_lane(buf_q, k) : 8'h00;
  end

  assign window_bytes = count_q >= CNT_W'(LINE_BYTES) ? 5'd16 : count_q[4:0];
  assign overrun = overrun_q;
endmodule

// File: tb/tb_decode_byte_aligner.sv
// tb_decode_byte_aligner: table-driven and randomized scoreboard bench for decode_byte_aligner
module tb_decode_byte_aligner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic [127:0] fetch_data = '0;
  logic fetch_valid = 1'b0;
  logic fetch_ready;
  logic [127:0] window;
  logic [4:0] window_bytes;
  logic consume_valid = 1'b0;
  logic [4:0] consume_bytes = '0;
  logic overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] win;
    logic [4:0]   wb;
    logic         rdy;
    logic         ov;
  } exp_t;

  typedef struct {
    bit         fl;
    bit         fv;
    logic [7:0] base;
    bit         cv;
    logic [4:0] cb;
    logic [4:0] wb;
    logic [7:0] b0;
    bit         rdy;
    bit         ov;
  } vec_t;

  exp_t sb[$];
  logic [7:0] mq[$];
  bit m_ov = 1'b0;
  vec_t tbl[15];

  always #5 clk = ~clk;

  decode_byte_aligner dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .fetch_data(fetch_data),
    .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready),
    .window(window),
    .window_bytes(window_bytes),
    .consume_valid(consume_valid),
    .consume_bytes(consume_bytes),
    .overrun(overrun)
  );

  function automatic logic [127:0] line(input logic [7:0] b);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = b + 8'(k);
    return r;
  endfunction

  function automatic vec_t mk(input bit fl, fv, input logic [7:0] base, input bit cv, input logic [4:0] cb,
                              input logic [4:0] wb, input logic [7:0] b0, input bit rdy, ov);
    vec_t v;
    v.fl = fl; v.fv = fv; v.base = base; v.cv = cv; v.cb = cb;
    v.wb = wb; v.b0 = b0; v.rdy = rdy; v.ov = ov;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int sz;
    sz = mq.size();
    e.wb = sz > 16 ? 5'd16 : 5'(sz);
    e.rdy = sz <= 16;
    e.ov = m_ov;
    for (int k = 0; k < 16; k++) e.win[k*8 +: 8] = k < sz ? mq[k] : 8'h00;
    return e;
  endfunction

  task automatic step(input bit fl, fv, input logic [127:0] d, input bit cv, input logic [4:0] cb);
    exp_t e;
    int c;
    bit rdy;
    flush = fl; fetch_valid = fv; fetch_data = d; consume_valid = cv; consume_bytes = cb;
    rdy = mq.size() <= 16;
    if (fl) mq.delete();
    else begin
      c = cv ? int'(cb) : 0;
      if (c > 16) begin c = 16; m_ov = 1'b1; end
      if (c > mq.size()) begin c = mq.size(); m_ov = 1'b1; end
      repeat (c) void'(mq.pop_front());
      if (fv && rdy) for (int k = 0; k < 16; k++) mq.push_back(d[k*8 +: 8]);
    end
    sb.push_back(model_out());
    @(posedge clk);
    @(negedge clk);
    flush = 0; fetch_valid = 0; consume_valid = 0; consume_bytes = '0;
    e = sb.pop_front();
    chk("window", window, e.win);
    chk("window_bytes", 128'(window_bytes), 128'(e.wb));
    chk("fetch_ready", 128'(fetch_ready), 128'(e.rdy));
    chk("overrun", 128'(overrun), 128'(e.ov));
  endtask

  initial begin
    tbl[0]  = mk(0, 1, 8'h00, 0, 5'd0,  5'd16, 8'h00, 1, 0);
    tbl[1]  = mk(0, 1, 8'h10, 0, 5'd0,  5'd16, 8'h00, 0, 0);
    tbl[2]  = mk(0, 1, 8'h20, 0, 5'd0,  5'd16, 8'h00, 0, 0);
    tbl[3]  = mk(0, 1, 8'h20, 1, 5'd6,  5'd16, 8'h06, 0, 0);
    tbl[4]  = mk(0, 0, 8'h00, 1, 5'd10, 5'd16, 8'h10, 1, 0);
    tbl[5]  = mk(1, 1, 8'h30, 1, 5'd5,  5'd0,  8'h00, 1, 0);
    tbl[6]  = mk(0, 1, 8'h00, 0, 5'd0,  5'd16, 8'h00, 1, 0);
    tbl[7]  = mk(0, 1, 8'h10, 1, 5'd3,  5'd16, 8'h03, 0, 0);
    tbl[8]  = mk(0, 0, 8'h00, 1, 5'd16, 5'd13, 8'h13, 1, 0);
    tbl[9]  = mk(0, 0, 8'h00, 1, 5'd9,  5'd4,  8'h1C, 1, 0);
    tbl[10] = mk(0, 0, 8'h00, 1, 5'd9,  5'd0,  8'h00, 1, 1);
    tbl[11] = mk(1, 0, 8'h00, 0, 5'd0,  5'd0,  8'h00, 1, 1);
    tbl[12] = mk(0, 0, 8'h00, 1, 5'd0,  5'd0,  8'h00, 1, 1);
    tbl[13] = mk(0, 1, 8'h40, 0, 5'd0,  5'd16, 8'h40, 1, 1);
    tbl[14] = mk(0, 0, 8'h00, 1, 5'd16, 5'd0,  8'h00, 1, 1);

    #1;
    chk("reset_window", window, 128'h0);
    chk("reset_state", {125'h0, window_bytes == 5'd0, fetch_ready, overrun}, 128'b110);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].fl, tbl[i].fv, line(tbl[i].base), tbl[i].cv, tbl[i].cb);
      chk($sformatf("vec%0d", i), {99'h0, window_bytes, window[7:0], fetch_ready, overrun},
          {99'h0, tbl[i].wb, tbl[i].b0, tbl[i].rdy, tbl[i].ov});
    end

    // Asynchronous reset between edges must clear everything before the next edge.
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    mq.delete();
    m_ov = 1'b0;
    chk("async_window", window, 128'h0);
    chk("async_state", {125'h0, window_bytes == 5'd0, fetch_ready, overrun}, 128'b110);
    @(negedge clk);
    reset = 1'b0;

    step(0, 1, line(8'h50), 0, 5'd0);
    chk("post_reset_byte0", 128'(window[7:0]), 128'h50);
    step(0, 1, line(8'h60), 0, 5'd0);
    step(0, 0, '0, 1, 5'd20);
    chk("illegal_consume", {110'h0, window_bytes, window[7:0], fetch_ready, overrun},
        {110'h0, 5'd16, 8'h60, 1'b1, 1'b1});

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 17)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
